// File: rtl/clk_pkg.sv
// clk_pkg: shared FSM state encoding, ratio codes and pair classifier for clk_ratio_detect
package clk_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    DIV2    = 3'd1,
    DIV3_33 = 3'd2,
    DIV3_67 = 3'd3,
    DIV4    = 3'd4,
    OTHER   = 3'd7
  } ratio_t;
  function automatic ratio_t classify(input int unsigned h, input int unsigned l);
    return (h == 1 && l == 1) ? DIV2 :
           (h == 1 && l == 2) ? DIV3_33 :
           (h == 2 && l == 1) ? DIV3_67 :
           (h == 2 && l == 2) ? DIV4 : OTHER;
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer plus history flop with edge detection
//   clock_in : reference clock, rising edge
//   reset    : synchronous, active-low
//   probe    : asynchronous input
//   level    : synchronized probe level
//   rise     : one-cycle pulse on synchronized 0->1
//   fall     : one-cycle pulse on synchronized 1->0
module sync_edge (
  input  logic clock_in,
  input  logic reset,
  input  logic probe,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, hist_q;
  always_ff @(posedge clock_in) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= probe;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end
  assign level = s2_q;
  assign rise  = s2_q & ~hist_q;
  assign fall  = ~s2_q & hist_q;
endmodule

// File: rtl/clk_ratio_detect.sv
// clk_ratio_detect: measures high/low time of a divided probe clock and classifies the divide ratio
//   clock_in   : reference clock, rising edge
//   reset      : synchronous, active-low
//   probe      : divided clock under measurement (asynchronous)
//   high_len   : high time of last completed period, clock_in cycles
//   low_len    : low time of last completed period, clock_in cycles
//   meas_stb   : one-cycle pulse per completed period
//   valid      : lock, STABLE_N identical consecutive periods
//   ratio_code : classified ratio, NONE unless locked
//   led        : registered board indicator, ratio_code when locked
module clk_ratio_detect
  import clk_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int STABLE_N = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             probe,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             meas_stb,
  output logic             valid,
  output logic [2:0]       ratio_code,
  output logic [2:0]       led
);
  localparam int SW = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_N);
  localparam logic [SW-1:0] STAB_ONE = SW'(1);
  logic level, rise, fall;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcap_q, hcap_d;
  logic [CNT_W-1:0] high_len_q, high_len_d, low_len_q, low_len_d;
  logic [SW-1:0] stab_q, stab_d;
  logic stb_q, stb_d, valid_q, valid_d;
  logic [2:0] code_q, code_d, led_q, led_d;
  logic timeout, same;
  sync_edge u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .probe    (probe),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );
  assign timeout = (state_q != IDLE) && (cnt_q == CNT_MAX);
  assign same    = (hcap_q == high_len_q) && (cnt_q == low_len_q);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcap_d     = hcap_q;
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    stb_d      = 1'b0;
    stab_d     = stab_q;
    valid_d    = valid_q;
    code_d     = code_q;
    if (timeout) begin
      state_d = IDLE;
      cnt_d   = '0;
      stab_d  = '0;
      valid_d = 1'b0;
      code_d  = NONE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = rise ? MEAS_HIGH : IDLE;
          cnt_d   = rise ? CNT_ONE : cnt_q;
        end
        MEAS_HIGH: begin
          state_d = fall ? MEAS_LOW : MEAS_HIGH;
          cnt_d   = fall ? CNT_ONE : cnt_q + 1'b1;
          hcap_d  = fall ? cnt_q : hcap_q;
        end
        MEAS_LOW: begin
          // the first high level seen in MEAS_LOW is by construction the rise
          if (level) begin
            state_d    = MEAS_HIGH;
            cnt_d      = CNT_ONE;
            high_len_d = hcap_q;
            low_len_d  = cnt_q;
            stb_d      = 1'b1;
            stab_d     = !same ? STAB_ONE : (stab_q == STAB_MAX ? stab_q : stab_q + 1'b1);
            valid_d    = stab_d == STAB_MAX;
            code_d     = valid_d ? classify(32'(hcap_q), 32'(cnt_q)) : NONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    led_d = valid_d ? code_d : NONE;
  end
  always_ff @(posedge clock_in) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hcap_q     <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      stb_q      <= 1'b0;
      stab_q     <= '0;
      valid_q    <= 1'b0;
      code_q     <= NONE;
      led_q      <= NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcap_q     <= hcap_d;
      high_len_q <= high_len_d;
      low_len_q  <= low_len_d;
      stb_q      <= stb_d;
      stab_q     <= stab_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      led_q      <= led_d;
    end
  end
  assign high_len   = high_len_q;
  assign low_len    = low_len_q;
  assign meas_stb   = stb_q;
  assign valid      = valid_q;
  assign ratio_code = code_q;
  assign led        = led_q;
endmodule

// File: tb/tb_clk_ratio_detect.sv
// tb_clk_ratio_detect: directed and randomized checks of clk_ratio_detect against a period-level model
module tb_clk_ratio_detect;
  import clk_pkg::*;
  localparam int N = 2;
  logic clock_in = 1'b0;
  logic reset = 1'b0;
  logic probe = 1'b0;
  logic [7:0] high_len, low_len;
  logic meas_stb, valid;
  logic [2:0] ratio_code, led;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [7:0] h;
    logic [7:0] l;
    logic v;
    logic [2:0] c;
    logic [2:0] led;
  } rec_t;
  typedef struct {
    int h;
    int l;
  } pair_t;
  rec_t obs_q[$];
  pair_t pq[$];
  clk_ratio_detect dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .probe      (probe),
    .high_len   (high_len),
    .low_len    (low_len),
    .meas_stb   (meas_stb),
    .valid      (valid),
    .ratio_code (ratio_code),
    .led        (led)
  );
  always #5 clock_in = ~clock_in;
  always @(negedge clock_in)
    if (meas_stb === 1'b1) obs_q.push_back('{high_len, low_len, valid, ratio_code, led});
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  function automatic logic [2:0] ref_code(input int h, input int l);
    if (h == 1 && l == 1) return 3'd1;
    if (h == 1 && l == 2) return 3'd2;
    if (h == 2 && l == 1) return 3'd3;
    if (h == 2 && l == 2) return 3'd4;
    return 3'd7;
  endfunction
  task automatic run(input logic v, input int n);
    probe = v;
    repeat (n) @(negedge clock_in);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    probe = 1'b0;
    repeat (2) @(negedge clock_in);
    reset = 1'b1;
    obs_q.delete();
    pq.delete();
  endtask
  task automatic add(input int h, input int l, input int reps);
    repeat (reps) pq.push_back('{h, l});
  endtask
  // drive every queued period, then a trailing rise so the last one completes
  task automatic play();
    foreach (pq[i]) begin
      run(1'b1, pq[i].h);
      run(1'b0, pq[i].l);
    end
    run(1'b1, 1);
    run(1'b0, 8);
  endtask
  // expected per-period results: lock after N identical consecutive pairs
  task automatic check_phase(input string tag);
    int stab = 0;
    int ph = 0;
    int pl = 0;
    logic [2:0] code;
    chk({tag, "_stb_count"}, obs_q.size(), pq.size());
    foreach (pq[i]) begin
      stab = (pq[i].h == ph && pq[i].l == pl) ? (stab < N ? stab + 1 : N) : 1;
      ph = pq[i].h;
      pl = pq[i].l;
      code = (stab == N) ? ref_code(ph, pl) : 3'd0;
      if (i < obs_q.size()) begin
        chk($sformatf("%s_len%0d", tag, i), {obs_q[i].h, obs_q[i].l}, {8'(ph), 8'(pl)});
        chk($sformatf("%s_flags%0d", tag, i), {obs_q[i].v, obs_q[i].c, obs_q[i].led},
            {stab == N, code, code});
      end
    end
    obs_q.delete();
    pq.delete();
  endtask
  initial begin
    bit found;
    repeat (3) @(negedge clock_in);
    chk("reset_outputs", {high_len, low_len, meas_stb, valid, ratio_code, led}, 0);
    chk("reset_state", dut.state_q, IDLE);
    reset = 1'b1;
    // /2 for 10 periods
    do_reset();
    add(1, 1, 10);
    play();
    check_phase("div2");
    chk("div2_final_led", led, 3'b001);
    // /3 1h2l then 2h1l
    do_reset();
    add(1, 2, 4);
    add(2, 1, 4);
    play();
    chk("div3_lock2", {obs_q[1].v, obs_q[1].c}, {1'b1, 3'd2});
    chk("div3_drop", obs_q[4].v, 1'b0);
    chk("div3_lock3", {obs_q[5].v, obs_q[5].c}, {1'b1, 3'd3});
    check_phase("div3");
    // 5 high, 3 low -> OTHER
    do_reset();
    add(5, 3, 3);
    play();
    check_phase("h5l3");
    chk("h5l3_final", {high_len, low_len, valid, ratio_code}, {8'd5, 8'd3, 1'b1, 3'd7});
    // randomized period streams
    repeat (3) begin
      do_reset();
      for (int i = 0; i < 10; i++) begin
        int sel = $urandom_range(0, 5);
        int reps = $urandom_range(1, 3);
        case (sel)
          0: add(1, 1, reps);
          1: add(1, 2, reps);
          2: add(2, 1, reps);
          3: add(2, 2, reps);
          default: add($urandom_range(1, 6), $urandom_range(1, 6), reps);
        endcase
      end
      play();
      check_phase("rand");
    end
    // locked /2 then probe held high -> timeout
    do_reset();
    add(1, 1, 4);
    foreach (pq[i]) begin
      run(1'b1, 1);
      run(1'b0, 1);
    end
    run(1'b1, 10);
    check_phase("hold_pre");
    run(1'b1, 290);
    chk("hold_no_stb", obs_q.size(), 0);
    chk("hold_outputs", {valid, ratio_code, led}, 0);
    chk("hold_state_idle", dut.state_q, IDLE);
    // reset during MEAS_LOW of a locked /2 stream
    do_reset();
    repeat (6) begin
      run(1'b1, 1);
      run(1'b0, 1);
    end
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (dut.state_q === MEAS_LOW) found = 1'b1;
      else run(~probe, 1);
    end
    chk("rst_found_meas_low", found, 1'b1);
    chk("rst_locked_before", {valid, ratio_code}, {1'b1, 3'd1});
    reset = 1'b0;
    run(~probe, 1);
    chk("rst_outputs_zero", {high_len, low_len, meas_stb, valid, ratio_code, led}, 0);
    chk("rst_state_idle", dut.state_q, IDLE);
    reset = 1'b1;
    obs_q.delete();
    repeat (16) run(~probe, 1);
    chk("relock_stb_count", obs_q.size() >= 2, 1'b1);
    chk("relock_first", {obs_q[0].h, obs_q[0].l, obs_q[0].v}, {8'd1, 8'd1, 1'b0});
    chk("relock_second", {obs_q[1].h, obs_q[1].l, obs_q[1].v, obs_q[1].c, obs_q[1].led},
        {8'd1, 8'd1, 1'b1, 3'd1, 3'd1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
